// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer backed by a byte-strobed word array,
// with a fixed number of wait states and an out-of-range error response.
module apb_slave_mem #(
    parameter int ADD_WIDTH   = 8,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [WIDTH/8-1:0]   pstrb,
    input  logic [ADD_WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0]     pwdata,
    output logic [WIDTH-1:0]     prdata,
    output logic                 pready,
    output logic                 pslverr
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NB = WIDTH / 8;
    localparam logic [ADD_WIDTH:0] DEPTH_L = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             err, done;
    logic [IW-1:0]    idx;

    assign err     = {1'b0, paddr} >= DEPTH_L;
    assign idx     = paddr[IW-1:0];
    assign done    = state == ACCESS && psel && penable && cnt == 4'd0;
    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = (done && !err && !pwrite) ? mem[idx] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A dropped psel aborts; a fresh setup while in ACCESS restarts the wait.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (psel && !penable) begin
                state_nxt = ACCESS;
                cnt_nxt   = WAIT_L;
            end
        end else if (!psel) begin
            state_nxt = IDLE;
        end else if (!penable) begin
            cnt_nxt = WAIT_L;
        end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (done && pwrite && !err) begin
            for (int b = 0; b < NB; b++)
                if (pstrb[b]) mem[idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: table-driven transfers on a one-wait-state instance plus
// hand-built abort, reset and zero-wait back-to-back sequences.
module tb_apb_slave_mem;
    logic        pclk = 0, presetn = 0, psel = 0, penable = 0, pwrite = 0, sel0 = 0;
    logic [3:0]  pstrb = 0;
    logic [7:0]  paddr = 0;
    logic [31:0] pwdata = 0;
    logic [31:0] prdata_a, prdata_b, prdata;
    logic        pready_a, pready_b, pready, pslverr_a, pslverr_b, pslverr;
    int          cyc = 0, checks = 0, failures = 0;

    apb_slave_mem #(.WAIT_CYCLES(1)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel && !sel0), .penable(penable),
        .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

    apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel && sel0), .penable(penable),
        .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

    assign prdata  = sel0 ? prdata_b  : prdata_a;
    assign pready  = sel0 ? pready_b  : pready_a;
    assign pslverr = sel0 ? pslverr_b : pslverr_a;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that follows completion.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n = 0;
        bit   ok = 0;
        sb.push_back({exp_rd, exp_err});
        psel = 1; penable = 0; pwrite = w; paddr = a; pstrb = s; pwdata = d;
        @(posedge pclk); #1;
        penable = 1;
        while (!ok && n < 20) begin
            @(negedge pclk);
            n++;
            if (pready) ok = 1;
            else begin
                chk("wait_prdata", prdata, 32'h0);
                chk("wait_pslverr", {31'b0, pslverr}, 32'h0);
                @(posedge pclk); #1;
            end
        end
        e = sb.pop_front();
        if (!ok) begin
            checks++; failures++;
            $display("FAIL timeout addr=%h: got no pready expected pready within 20 cycles", a);
        end else begin
            chk("prdata", prdata, e.rdata);
            chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
            chk("latency", 32'(n), sel0 ? 32'd1 : 32'd2);
        end
        @(posedge pclk); #1;
        psel = 0; penable = 0;
    endtask

    vec_t vecs[12];
    int   c0;

    initial begin
        vecs[0]  = '{0, 8'd5,   4'hF, 32'h0,        32'h0,        0};
        vecs[1]  = '{1, 8'd0,   4'hF, 32'h0BADF00D, 32'h0,        0};
        vecs[2]  = '{1, 8'd3,   4'hF, 32'hDEADBEEF, 32'h0,        0};
        vecs[3]  = '{1, 8'd3,   4'h5, 32'h11223344, 32'h0,        0};
        vecs[4]  = '{0, 8'd3,   4'h0, 32'h0,        32'hDE22BE44, 0};
        vecs[5]  = '{1, 8'd64,  4'hF, 32'hFFFFFFFF, 32'h0,        1};
        vecs[6]  = '{0, 8'd0,   4'hF, 32'h0,        32'h0BADF00D, 0};
        vecs[7]  = '{0, 8'd64,  4'hF, 32'h0,        32'h0,        1};
        vecs[8]  = '{1, 8'd3,   4'h0, 32'h0,        32'h0,        0};
        vecs[9]  = '{0, 8'd3,   4'hF, 32'h0,        32'hDE22BE44, 0};
        vecs[10] = '{1, 8'd63,  4'hA, 32'h12345678, 32'h0,        0};
        vecs[11] = '{0, 8'd63,  4'h0, 32'h0,        32'h12005600, 0};

        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("reset_pready", {31'b0, pready_a | pready_b}, 32'h0);
        chk("reset_pslverr", {31'b0, pslverr_a | pslverr_b}, 32'h0);
        chk("reset_prdata", prdata_a | prdata_b, 32'h0);
        @(posedge pclk); #1;
        presetn = 1;
        @(posedge pclk); #1;

        for (int i = 0; i < 12; i++)
            xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_err);

        // abort a write to 7 after one access cycle, then read it straight back
        psel = 1; penable = 0; pwrite = 1; paddr = 8'd7; pstrb = 4'hF; pwdata = 32'hCAFEF00D;
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        chk("abort_pready", {31'b0, pready}, 32'h0);
        @(posedge pclk); #1;
        psel = 0; penable = 0;
        @(posedge pclk); #1;
        xfer(0, 8'd7, 4'hF, 32'h0, 32'h0, 0);

        // reset lands in the completing access cycle of a write to 20
        psel = 1; penable = 0; pwrite = 1; paddr = 8'd20; pstrb = 4'hF; pwdata = 32'h55AA55AA;
        @(posedge pclk); #1;
        penable = 1;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("pre_reset_pready", {31'b0, pready}, 32'h1);
        presetn = 0;
        #1;
        chk("mid_reset_pready", {31'b0, pready}, 32'h0);
        chk("mid_reset_prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        psel = 0; penable = 0; presetn = 1;
        @(posedge pclk); #1;
        xfer(0, 8'd20, 4'hF, 32'h0, 32'h0, 0);
        xfer(0, 8'd3,  4'hF, 32'h0, 32'h0, 0);

        // zero-wait back-to-back write then read
        sel0 = 1;
        @(posedge pclk); #1;
        c0 = cyc;
        xfer(1, 8'd10, 4'hF, 32'hA5A5A5A5, 32'h0, 0);
        xfer(0, 8'd10, 4'hF, 32'h0, 32'hA5A5A5A5, 0);
        chk("b2b_cycles", 32'(cyc - c0), 32'd4);
        xfer(1, 8'd200, 4'hF, 32'h1, 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB4 completer that answers the APB master: a byte-strobed register/memory array with a configurable number of wait states and an error response.
- Sits behind one master select line (psel_1 or psel_2 side) and receives paddr with the select bit already stripped.
- Serves as the standard target for system integration and for master verification.

Parameters:
- ADD_WIDTH, 8, paddr width; this is the master's address width minus 1.
- WIDTH, 32, data width; must be a multiple of 8.
- DEPTH, 64, number of WIDTH-bit words implemented; must be <= 2**ADD_WIDTH.
- WAIT_CYCLES, 1, wait states inserted per transfer; range 0..15.

Ports:
- pclk, input, 1, clock.
- presetn, input, 1, asynchronous active-low reset.
- psel, input, 1, select for this completer.
- penable, input, 1, access phase indicator.
- pwrite, input, 1, 1 = write, 0 = read.
- pstrb, input, WIDTH/8, byte write strobes.
- paddr, input, ADD_WIDTH, word index.
- pwdata, input, WIDTH, write data.
- prdata, output, WIDTH, read data.
- pready, output, 1, transfer complete.
- pslverr, output, 1, error response.

Behaviour:
- Reset (presetn low, asynchronous): state = IDLE, wait counter = 0, all DEPTH words cleared to 0. Reset released mid-transfer: the transfer is lost and the slave waits for a new setup phase.
- Outputs during reset: pready = 0, pslverr = 0, prdata = 0.
- FSM state IDLE:
  - psel=1 and penable=0 (setup phase): load counter with WAIT_CYCLES, go to ACCESS.
  - Otherwise: stay in IDLE.
- FSM state ACCESS:
  - psel=1, penable=1, counter != 0: decrement counter, stay in ACCESS. pready = 0.
  - psel=1, penable=1, counter == 0: pready = 1 (combinational); the transfer completes on this pclk edge; go to IDLE.
  - psel=0 (master abort): go to IDLE with no write and no error.
  - psel=1, penable=0 (new setup): reload counter, stay in ACCESS.
- Latency: pready rises in access cycle WAIT_CYCLES+1, counted from the first penable=1 cycle. With WAIT_CYCLES=0 the transfer is zero-wait, so setup plus access takes 2 cycles.
- Back-to-back transfers: setup directly following a completion is accepted from IDLE with no bubble.
- pready, pslverr and prdata are 0 in every cycle where the completion condition is false.
- Error condition: paddr >= DEPTH. pslverr = 1 only together with pready = 1.
  - Erroring write: no array update.
  - Erroring read: prdata = 0.
- Write: committed at the completing edge only, and only when there is no error. Byte i of the word is updated iff pstrb[i] = 1. pstrb = 0 is a legal no-op write.
- Read:
  - prdata = mem[paddr] combinationally during the completing cycle.
  - pstrb is ignored on reads.
  - A read sees all writes completed on earlier edges.
- Read and write addresses share one port; only one transfer is in flight at a time, so there are no simultaneous-access hazards.
- Wait counter: 4 bits, saturates at 0, and never underflows.

Test Plan:
- Reset, then read paddr=5 with WAIT_CYCLES=1 -> pready high in the 2nd access cycle, prdata=0x00000000, pslverr=0.
- Write paddr=3, pwdata=0xDEADBEEF, pstrb=4'b1111; then write paddr=3, pwdata=0x11223344, pstrb=4'b0101; then read paddr=3 -> prdata=0xDE22BE44.
- Write paddr=64 with DEPTH=64 -> pready and pslverr both high in the completing cycle. A following read of paddr=0 -> pslverr=0 and unchanged data, confirming no aliasing.
- Abort: setup a write to paddr=7, drop psel after 1 access cycle with the counter not yet expired -> read paddr=7 returns 0, and the FSM accepts the next setup immediately.
- Back-to-back with WAIT_CYCLES=0: write 0xA5A5A5A5 to paddr=10 followed by a read of paddr=10 -> 4 total cycles, pready=1 in cycles 2 and 4, read returns 0xA5A5A5A5.
- Assert presetn low during ACCESS of a write -> pready=0 immediately, the target word stays 0, and the FSM is in IDLE after release.
